// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Latches the winning request, runs the memory req/ack handshake with a timeout, returns the response.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_ack,
    output logic [DATA_WIDTH-1:0]   i_rdata,

    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_ack,
    output logic [DATA_WIDTH-1:0]   d_rdata,

    output logic                    err,

    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic                    sel,
    output logic                    busy
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]           state;
    logic                 last;      // 0 = fetch granted last, 1 = data granted last
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 win_d;

    // Data wins when alone, or under contention when fetch was served last.
    assign win_d = d_req & (~i_req | ~last);

    // NOTE: every register here is sequential state, so it is assigned only with <=
    // inside the clocked block; the async reset branch clears all of it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b0;
            wait_cnt  <= '0;
            sel       <= 1'b0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state    <= GRANT;
                        busy     <= 1'b1;
                        mem_req  <= 1'b1;
                        sel      <= win_d;
                        last     <= win_d;
                        wait_cnt <= '0;
                        if (win_d) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_wstrb <= d_wstrb;
                        end else begin
                            // Fetches are always reads; write data is left as it was.
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wstrb <= '0;
                        end
                    end
                end
                GRANT: begin
                    if (mem_ack) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        if (sel) begin
                            d_ack   <= 1'b1;
                            d_rdata <= mem_rdata;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        if (sel) begin
                            d_ack   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_WIDTH'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized requesters and memory checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [SW-1:0] d_wstrb = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          sel;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .sel(sel), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit            m_granted = 1'b0;    // a transaction holds the memory port
    bit            m_responding = 1'b0; // the response cycle of a finished transaction
    bit            m_owner = 1'b0;      // 1 = data side owns the transaction
    bit            m_last = 1'b0;
    int            m_waited = 0;
    logic          e_mem_req = 1'b0, e_mem_we = 1'b0, e_sel = 1'b0, e_busy = 1'b0;
    logic          e_i_ack = 1'b0, e_d_ack = 1'b0, e_err = 1'b0;
    logic [AW-1:0] e_mem_addr = '0;
    logic [DW-1:0] e_mem_wdata = '0, e_i_rdata = '0, e_d_rdata = '0;
    logic [SW-1:0] e_mem_wstrb = '0;

    task automatic model_complete(input bit timed_out, input logic [DW-1:0] val);
        m_granted    = 1'b0;
        m_responding = 1'b1;
        e_err        = timed_out;
        if (m_owner) begin
            e_d_ack   = 1'b1;
            e_d_rdata = val;
        end else begin
            e_i_ack   = 1'b1;
            e_i_rdata = val;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_granted = 1'b0; m_responding = 1'b0; m_last = 1'b0; m_waited = 0;
            e_mem_req = 1'b0; e_mem_we = 1'b0; e_sel = 1'b0; e_busy = 1'b0;
            e_i_ack = 1'b0; e_d_ack = 1'b0; e_err = 1'b0;
            e_mem_addr = '0; e_mem_wdata = '0; e_mem_wstrb = '0;
            e_i_rdata = '0; e_d_rdata = '0;
        end else begin
            e_i_ack = 1'b0;
            e_d_ack = 1'b0;
            e_err   = 1'b0;
            if (m_responding) begin
                m_responding = 1'b0;
            end else if (m_granted) begin
                m_waited++;
                if (mem_ack)              model_complete(1'b0, mem_rdata);
                else if (m_waited == TO)  model_complete(1'b1, '0);
            end else if (i_req || d_req) begin
                m_owner   = d_req && !(i_req && m_last);
                m_last    = m_owner;
                m_granted = 1'b1;
                m_waited  = 0;
                e_sel     = m_owner;
                if (m_owner) begin
                    e_mem_addr = d_addr; e_mem_we = d_we;
                    e_mem_wdata = d_wdata; e_mem_wstrb = d_wstrb;
                end else begin
                    e_mem_addr = i_addr; e_mem_we = 1'b0; e_mem_wstrb = '0;
                end
            end
            e_mem_req = m_granted;
            e_busy    = m_granted || m_responding;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check_bit ("mem_req",   mem_req,   e_mem_req);
            check_bit ("mem_we",    mem_we,    e_mem_we);
            check_word("mem_addr",  mem_addr,  e_mem_addr);
            check_word("mem_wdata", mem_wdata, e_mem_wdata);
            check_word("mem_wstrb", 32'(mem_wstrb), 32'(e_mem_wstrb));
            check_bit ("sel",       sel,       e_sel);
            check_bit ("busy",      busy,      e_busy);
            check_bit ("i_ack",     i_ack,     e_i_ack);
            check_bit ("d_ack",     d_ack,     e_d_ack);
            check_bit ("err",       err,       e_err);
            check_word("i_rdata",   i_rdata,   e_i_rdata);
            check_word("d_rdata",   d_rdata,   e_d_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic exp_sel [4];
        bit   i_done, d_done, mem_prev;
        int   lat, wc;

        #1 reset = 1'b1;
        @(negedge clk);
        check_bit ("rst_mem_req", mem_req, 1'b0);
        check_bit ("rst_busy",    busy,    1'b0);
        check_bit ("rst_sel",     sel,     1'b0);
        check_bit ("rst_err",     err,     1'b0);
        check_word("rst_i_rdata", i_rdata, 32'h0);
        check_word("rst_d_rdata", d_rdata, 32'h0);
        check_word("rst_mem_addr", mem_addr, 32'h0);
        tick();
        reset = 1'b0; cmp_en = 1'b1;

        // Lone fetch, memory acks in cycle 1.
        i_req = 1'b1; i_addr = 32'h100;
        tick(); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check_bit ("fetch_mem_req", mem_req, 1'b1);
        check_bit ("fetch_sel", sel, 1'b0);
        check_bit ("fetch_mem_we", mem_we, 1'b0);
        check_word("fetch_mem_addr", mem_addr, 32'h100);
        tick(); mem_ack = 1'b0;
        @(negedge clk);
        check_bit ("fetch_i_ack", i_ack, 1'b1);
        check_word("fetch_i_rdata", i_rdata, 32'hDEADBEEF);
        check_bit ("fetch_err", err, 1'b0);
        check_bit ("fetch_d_ack", d_ack, 1'b0);
        tick(); i_req = 1'b0;
        @(negedge clk);
        check_bit("fetch_idle", busy, 1'b0);

        // Store with three wait states; ack lands in the last allowed grant cycle.
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
        for (int c = 1; c <= 4; c++) begin
            tick(); mem_ack = (c == 4); mem_rdata = 32'hCAFE0001;
            @(negedge clk);
            check_bit ("store_mem_req", mem_req, 1'b1);
            check_bit ("store_sel", sel, 1'b1);
            check_bit ("store_mem_we", mem_we, 1'b1);
            check_word("store_mem_addr", mem_addr, 32'h200);
            check_word("store_mem_wdata", mem_wdata, 32'h12345678);
            check_word("store_mem_wstrb", 32'(mem_wstrb), 32'h3);
        end
        tick(); mem_ack = 1'b0;
        @(negedge clk);
        check_bit ("store_d_ack", d_ack, 1'b1);
        check_bit ("store_err", err, 1'b0);
        check_bit ("store_mem_req_low", mem_req, 1'b0);
        tick(); d_req = 1'b0; d_we = 1'b0;

        // Stray ack while idle.
        tick(); mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        tick(); mem_ack = 1'b0;
        @(negedge clk);
        check_bit ("stray_i_ack", i_ack, 1'b0);
        check_bit ("stray_d_ack", d_ack, 1'b0);
        check_bit ("stray_busy", busy, 1'b0);
        check_word("stray_i_rdata", i_rdata, 32'hDEADBEEF);
        check_word("stray_d_rdata", d_rdata, 32'hCAFE0001);

        // Timeout: memory never acks.
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wstrb = '0;
        for (int c = 1; c <= TO; c++) begin
            tick();
            @(negedge clk);
            check_bit("to_mem_req", mem_req, 1'b1);
        end
        tick();
        @(negedge clk);
        check_bit ("to_mem_req_low", mem_req, 1'b0);
        check_bit ("to_d_ack", d_ack, 1'b1);
        check_bit ("to_err", err, 1'b1);
        check_word("to_d_rdata", d_rdata, 32'h0);
        tick(); d_addr = 32'h304;
        tick(); mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        check_word("after_to_mem_addr", mem_addr, 32'h304);
        tick(); mem_ack = 1'b0;
        @(negedge clk);
        check_bit ("after_to_d_ack", d_ack, 1'b1);
        check_bit ("after_to_err", err, 1'b0);
        check_word("after_to_d_rdata", d_rdata, 32'h55AA55AA);
        tick(); d_req = 1'b0;

        // Contention held from reset: grants alternate D, I, D, I every 3 cycles.
        exp_sel[0] = 1'b1; exp_sel[1] = 1'b0; exp_sel[2] = 1'b1; exp_sel[3] = 1'b0;
        tick(); reset = 1'b1;
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h400; d_addr = 32'h500; d_we = 1'b0;
        tick(); reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick(); mem_ack = mem_req; mem_rdata = 32'(c);
            if (c == 12) begin i_req = 1'b0; d_req = 1'b0; end
            @(negedge clk);
            if (c % 3 == 1) begin
                check_bit("cont_mem_req", mem_req, 1'b1);
                check_bit("cont_sel", sel, exp_sel[(c - 1) / 3]);
            end else begin
                check_bit("cont_mem_req_low", mem_req, 1'b0);
            end
        end
        tick(); mem_ack = 1'b0;

        // Reset pulse during GRANT of a store; the pending fetch is served afterwards.
        i_req = 1'b1; i_addr = 32'h600;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h700; d_wdata = 32'h0BADF00D; d_wstrb = 4'hF;
        tick();
        @(negedge clk);
        check_bit("rstmid_sel_before", sel, 1'b1);
        tick();
        #2 reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
        #1;
        check_bit("rstmid_mem_req", mem_req, 1'b0);
        check_bit("rstmid_busy", busy, 1'b0);
        check_bit("rstmid_sel", sel, 1'b0);
        @(negedge clk);
        check_bit("rstmid_d_ack", d_ack, 1'b0);
        tick(); reset = 1'b0;
        tick(); mem_ack = 1'b1; mem_rdata = 32'h00000077;
        @(negedge clk);
        check_bit ("rstmid_fetch_req", mem_req, 1'b1);
        check_bit ("rstmid_fetch_sel", sel, 1'b0);
        check_word("rstmid_fetch_addr", mem_addr, 32'h600);
        tick(); mem_ack = 1'b0;
        @(negedge clk);
        check_bit ("rstmid_i_ack", i_ack, 1'b1);
        check_word("rstmid_i_rdata", i_rdata, 32'h00000077);
        tick(); i_req = 1'b0;

        // Randomized traffic: latency 0..6 grant cycles, so some accesses time out.
        i_done = 1'b0; d_done = 1'b0; mem_prev = 1'b0; lat = 0; wc = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (i_req && i_done) begin
                if ($urandom_range(0, 1) == 1) i_addr = $urandom;
                else i_req = 1'b0;
            end else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            i_done = i_ack;
            if (d_req && d_done) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom);
                end else begin
                    d_req = 1'b0;
                end
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
                d_wstrb = 4'($urandom);
            end
            d_done = d_ack;
            if (mem_req) begin
                if (!mem_prev) begin
                    lat = $urandom_range(0, 6);
                    wc  = 0;
                end
                mem_ack = (wc == lat);
                wc++;
            end else begin
                mem_ack = ($urandom_range(0, 7) == 0);
            end
            mem_prev  = mem_req;
            mem_rdata = $urandom;
        end
        tick(); i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch unit and the load/store unit. Arbitrates round-robin under contention, latches the winner's request, runs the req/ack handshake with memory (variable latency, bounded by a timeout), and returns the response to the granted requester. Drives `sel`, the select of the 2:1 address/data mux in front of the memory.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width; `DATA_WIDTH/8` strobe bits.
- `TIMEOUT`, default 255: maximum `GRANT` cycles waiting for `mem_ack` before abort; must be ≥ 1.

**Ports**
- `clk`, in, 1: the single clock, rising-edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `i_req`, in, 1: fetch request.
- `i_addr`, in, ADDR_WIDTH: fetch address.
- `i_ack`, out, 1: fetch response strobe, one cycle.
- `i_rdata`, out, DATA_WIDTH: fetch data, valid with `i_ack`.
- `d_req`, in, 1: load/store request.
- `d_we`, in, 1: 1 = store, 0 = load.
- `d_addr`, in, ADDR_WIDTH: load/store address.
- `d_wdata`, in, DATA_WIDTH: store data.
- `d_wstrb`, in, DATA_WIDTH/8: store byte enables.
- `d_ack`, out, 1: load/store response strobe, one cycle.
- `d_rdata`, out, DATA_WIDTH: load data, valid with `d_ack`.
- `err`, out, 1: with `i_ack`/`d_ack`, marks a timed-out access.
- `mem_req`, out, 1: memory request, held until ack or timeout.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, ADDR_WIDTH: memory address.
- `mem_wdata`, out, DATA_WIDTH: memory write data.
- `mem_wstrb`, out, DATA_WIDTH/8: memory byte enables.
- `mem_ack`, in, 1: memory completion; read data valid the same cycle.
- `mem_rdata`, in, DATA_WIDTH: memory read data.
- `sel`, out, 1: mux select, 0 = fetch, 1 = data.
- `busy`, out, 1: state ≠ `IDLE`.

## Operation

**FSM:** `IDLE` → `GRANT` → `RESP` → `IDLE`.

**IDLE**
- If `i_req` or `d_req` is high, pick the winner:
  - Only one requesting: that one wins.
  - Both requesting: the one not granted last wins, tracked by the `last` register.
- At the edge:
  - Latch the winner's address, `we`, `wdata` and `wstrb` into the mem_* registers.
  - A fetch grant forces `mem_we`=0 and `mem_wstrb`=0.
  - Set `sel` to the winner, update `last`, clear the timeout counter, go to `GRANT`.

**GRANT**
- `mem_req`=1; all mem_* outputs are stable.
- `mem_ack` sampled high:
  - Capture `mem_rdata` into the winner's rdata register; the other rdata register holds.
  - Go to `RESP` with `err`=0.
- Otherwise the counter increments. When it has counted `TIMEOUT` cycles without ack:
  - Go to `RESP` with `err`=1.
  - The winner's rdata register is loaded with 0.

**RESP**
- `mem_req`=0.
- Winner's ack is high for exactly one cycle; `err` is valid alongside it.
- Go to `IDLE`.

**Requester rules**
- Hold req and payload stable until its ack.
- Deassert req the cycle after ack unless issuing a new request.
- A req still high in `IDLE` is treated as a new request.

**Other rules**
- Requests arriving while `busy` are not sampled; they wait.
- `last` resets to fetch, so the first simultaneous request grants data.
- `sel` holds its value outside `GRANT`.

## Timing

- Reset asynchronous. State = `IDLE`, `last` = fetch. All outputs 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `sel`, `i_ack`, `d_ack`, `err`, `busy`, and both rdata registers.
- Reset mid-transaction drops `mem_req` immediately; no ack or err is issued for the aborted access.
- Cycle numbering: req high in cycle 0 → `mem_req` high in cycle 1.
- `mem_ack` in cycle k (k ≥ 1) → requester ack in cycle k+1 → `IDLE` in cycle k+2.
- Back-to-back throughput is one access per 3 cycles with a zero-wait memory.
- Timeout: `mem_req` stays high for exactly `TIMEOUT` cycles, `err` ack follows in the next cycle.
- `mem_ack` in the last `GRANT` cycle counts as success, not timeout.
- `mem_ack` outside `GRANT` is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- **Lone fetch:** `i_req`, `i_addr`=0x100; memory acks in cycle 1 with 0xDEADBEEF → `sel`=0, `mem_we`=0, `mem_addr`=0x100; `i_ack`=1 in cycle 2 with `i_rdata`=0xDEADBEEF, `err`=0; `d_ack` stays 0.
- **Store with wait states:** `d_req`, `d_we`=1, `d_addr`=0x200, `d_wdata`=0x12345678, `d_wstrb`=4'b0011; memory acks after 3 wait cycles → `mem_req` high in cycles 1–4 with stable fields and `sel`=1; `d_ack` in cycle 5.
- **Contention:** `i_req` and `d_req` both held continuously from reset → grants alternate D, I, D, I, one per 3 cycles.
- **Timeout:** `TIMEOUT`=4, memory never acks → `mem_req` high for 4 cycles, then `d_ack`=1, `err`=1, `d_rdata`=0; the next request completes normally with `err`=0.
- **Reset mid-access:** `reset` pulsed while in `GRANT` → `mem_req`, `busy` and `sel` drop without waiting for a clock edge; no ack issued; after release, a pending `i_req` is granted normally.
- **Stray ack:** `mem_ack` asserted while `IDLE` → no ack output, rdata registers unchanged.
